// File: rtl/lcd_disp_pkg.sv
// lcd_disp_pkg: shared widths, blank name and FSM state
// for the multi-slot LCD display sequencer.
package lcd_disp_pkg;

  localparam int NAME_W  = 40;
  localparam int VALUE_W = 32;
  localparam int NUM_W   = 6;

  localparam logic [NAME_W-1:0] BLANK_NAME =
    40'h2020202020;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

endpackage

// File: rtl/lcd_disp_rr_pick.sv
// lcd_disp_rr_pick: round-robin first-set finder.
// Scans vec starting at ptr, wrapping at NUM_CH.
module lcd_disp_rr_pick
  import lcd_disp_pkg::*;
#(
  parameter int NUM_CH = 8,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] vec,
  input  logic [CHW-1:0]    ptr,
  output logic              found,
  output logic [CHW-1:0]    idx
);

  // walk offsets from far to near so the nearest set bit wins
  always_comb begin
    logic [CHW:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (CHW+1)'(i);
      if (pos >= (CHW+1)'(NUM_CH))
        pos = pos - (CHW+1)'(NUM_CH);
      if (vec[pos[CHW-1:0]]) begin
        found = 1'b1;
        idx   = pos[CHW-1:0];
      end
    end
  end

endmodule

// File: rtl/lcd_disp_seq.sv
// lcd_disp_seq: event-driven multi-slot LCD sequencer.
// Option macro LCD_DISP_REFRESH_EN adds a periodic repaint.
module lcd_disp_seq
  import lcd_disp_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int BASE_NUM       = 1,
  parameter int GAP_CYCLES     = 16,
  parameter int INPUT_CH       = 0,
  parameter int REFRESH_CYCLES = 50_000_000,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [CHW-1:0]     wr_ch,
  input  logic [NAME_W-1:0]  wr_name,
  input  logic [VALUE_W-1:0] wr_value,
  input  logic               input_valid,
  input  logic [VALUE_W-1:0] input_value,
  output logic               display_valid,
  output logic [NAME_W-1:0]  display_name,
  output logic [VALUE_W-1:0] display_value,
  output logic [NUM_W-1:0]   display_number,
  output logic               busy,
  output logic [CHW:0]       pending_cnt
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [NAME_W-1:0]  name_q  [NUM_CH];
  logic [NAME_W-1:0]  name_d  [NUM_CH];
  logic [VALUE_W-1:0] value_q [NUM_CH];
  logic [VALUE_W-1:0] value_d [NUM_CH];
  logic [NUM_CH-1:0]  dirty_q, dirty_d;
  logic [NUM_CH-1:0]  set_v, clr_v;

  state_e             state_q, state_d;
  logic [CHW-1:0]     ptr_q, ptr_d;
  logic [CHW-1:0]     sel_q, sel_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [NAME_W-1:0]  dname_q, dname_d;
  logic [VALUE_W-1:0] dval_q, dval_d;
  logic [NUM_W-1:0]   dnum_q, dnum_d;

  logic               pick_found;
  logic [CHW-1:0]     pick_idx;
  logic               wr_hit;
  logic               refresh;

  assign wr_hit = wr_en && (32'(wr_ch) < NUM_CH);

`ifdef LCD_DISP_REFRESH_EN
  localparam int RW =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  logic [RW-1:0] rcnt_q, rcnt_d;

  // free-running repaint timer, pulses on wrap
  always_comb begin
    refresh = (rcnt_q == RW'(REFRESH_CYCLES - 1));
    rcnt_d  = refresh ? '0 : rcnt_q + 1'b1;
  end

  // repaint timer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end
`else
  assign refresh = 1'b0;
`endif

  lcd_disp_rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .vec   (dirty_q),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // slot storage update; host write beats touch input
  always_comb begin
    name_d  = name_q;
    value_d = value_q;
    set_v   = '0;
    if (wr_hit) begin
      name_d[wr_ch]  = wr_name;
      value_d[wr_ch] = wr_value;
      set_v[wr_ch]   = 1'b1;
    end
    if (input_valid &&
        !(wr_hit && wr_ch == CHW'(INPUT_CH))) begin
      value_d[INPUT_CH] = input_value;
      set_v[INPUT_CH]   = 1'b1;
    end
    dirty_d = (dirty_q & ~clr_v) | set_v
            | {NUM_CH{refresh}};
  end

  // slot storage; everything dirty out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        name_q[i]  <= BLANK_NAME;
        value_q[i] <= '0;
      end
      dirty_q <= '1;
    end else begin
      name_q  <= name_d;
      value_q <= value_d;
      dirty_q <= dirty_d;
    end
  end

  // pick / send / gap sequencing
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
    dname_d = dname_q;
    dval_d  = dval_q;
    dnum_d  = dnum_q;
    clr_v   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          dname_d = name_q[pick_idx];
          dval_d  = value_q[pick_idx];
          dnum_d  = NUM_W'(BASE_NUM)
                  + NUM_W'(pick_idx);
          state_d = SEND;
        end
      end
      SEND: begin
        clr_v[sel_q] = 1'b1;
        ptr_d = (sel_q == CHW'(NUM_CH - 1))
              ? '0 : sel_q + 1'b1;
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1))
          state_d = IDLE;
        else
          gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // sequencer and latched output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gap_q   <= '0;
      dname_q <= '0;
      dval_q  <= '0;
      dnum_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
      dname_q <= dname_d;
      dval_q  <= dval_d;
      dnum_q  <= dnum_d;
    end
  end

  // dirty-bit popcount
  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < NUM_CH; i++)
      pending_cnt = pending_cnt + (CHW+1)'(dirty_q[i]);
  end

  assign busy           = (state_q != IDLE) || (|dirty_q);
  assign display_valid  = (state_q == SEND);
  assign display_name   = dname_q;
  assign display_value  = dval_q;
  assign display_number = dnum_q;

endmodule

// File: doc/lcd_disp_seq.md
# lcd_disp_seq

Parametrised multi-channel display sequencer that feeds the `lcd_module` display port (`display_valid` / `display_name` / `display_value` / `display_number`). It holds `NUM_CH` name/value slots written by the host or by touch input, tracks which slots changed, and replays dirty slots to the LCD one at a time in round-robin order. Between sends it inserts a programmable gap. It replaces a free-running constant-driving top with an event-driven, multi-slot front end.

## Interface
Parameters:
- `NUM_CH`, 8, number of slots (1..64).
- `BASE_NUM`, 1, `display_number` of slot 0; `BASE_NUM+NUM_CH-1` ≤ 63.
- `GAP_CYCLES`, 16, idle cycles after each send (≥1).
- `INPUT_CH`, 0, slot receiving touch `input_value` (< `NUM_CH`).
- `REFRESH_CYCLES`, 50_000_000, forced-refresh period (used only with the refresh macro).

Derived: `CHW = max(1, $clog2(NUM_CH))`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `wr_en` in 1: host write strobe.
- `wr_ch` in CHW: target slot.
- `wr_name` in 40: 5 ASCII chars, MSB = first char.
- `wr_value` in 32: value.
- `input_valid` in 1: touch value strobe from `lcd_module`.
- `input_value` in 32: touch value.
- `display_valid` out 1: one-cycle send pulse.
- `display_name` out 40: name being sent.
- `display_value` out 32: value being sent.
- `display_number` out 6: LCD position, `BASE_NUM+slot`.
- `busy` out 1: state≠IDLE or any dirty bit set.
- `pending_cnt` out CHW+1: popcount of dirty bits.

## Operation
- Storage: per-slot `name[39:0]`, `value[31:0]`, `dirty`.
- Reset: names = five spaces (`0x2020202020`), values 0, all dirty bits 1 so the screen is painted after reset. Output regs `display_*` = 0, state IDLE, round-robin pointer = 0.
- Host write, `wr_en && wr_ch < NUM_CH`: name and value updated, dirty set. `wr_ch ≥ NUM_CH` is ignored.
- Touch input, `input_valid`: `value[INPUT_CH]` updated, dirty set, name unchanged. If `wr_en` targets `INPUT_CH` in the same cycle, the host write wins and the touch value is dropped.
- FSM:
  - IDLE: pick first dirty slot at or after the pointer, wrapping. If one is found, latch its name, value and number into the output regs and go to SEND.
  - SEND (1 cycle): `display_valid`=1; clear that slot's dirty bit; pointer = slot+1, wrapping at `NUM_CH`; go to GAP.
  - GAP: count `GAP_CYCLES`, then go to IDLE.
- Set beats clear: a write (or refresh) to the slot in its SEND cycle leaves it dirty, so it is sent again.
- Writes during GAP are stored normally. The latched outputs never change mid-send.
- `display_name`, `display_value` and `display_number` hold their last sent values outside SEND.

## Timing
- Write at cycle t, FSM idle, nothing else dirty: dirty seen at t+1 (IDLE pick), `display_valid` high at t+2.
- Back-to-back sends: pulses are spaced `GAP_CYCLES+2` cycles apart (SEND + GAP + IDLE).
- Full drain of N dirty slots: N pulses; `busy` drops the cycle after the last GAP ends with no dirty bits.
- `pending_cnt` and `busy` are combinational from registered state.
- Asynchronous reset mid-operation: outputs go to reset values immediately, any in-flight send is abandoned, all slots become dirty again.

## Configuration
- `LCD_DISP_REFRESH_EN` defined: a free-running counter, period `REFRESH_CYCLES`, ORs all-ones into the dirty vector on wrap. This refreshes the whole screen; set wins over a same-cycle clear.
- Undefined: no counter, and only writes or touch input cause sends.

## Structure
- Package `lcd_disp_pkg`: `NAME_W=40`, `VALUE_W=32`, `NUM_W=6`, `BLANK_NAME=40'h2020202020`, FSM state enum (IDLE, SEND, GAP).
- Sub-module `lcd_disp_rr_pick`: round-robin first-set finder over the dirty vector from the pointer. Outputs `found` and `idx`.

## Test plan
- Reset, `NUM_CH`=4, `BASE_NUM`=1, `GAP_CYCLES`=4 → four pulses, numbers 1,2,3,4, names blank, values 0, 6 cycles apart; then `busy`=0, `pending_cnt`=0.
- Idle, write slot 2 `"Data"`/32'd20241106 at t → `display_valid` at t+2 with number 3, name `"Data"`, value 20241106.
- Pointer at 2, write slots 0, 3, 1 on consecutive cycles → send order 3, 0, 1; `pending_cnt` peaks at 3.
- Same cycle: `input_valid` with 32'hDEADBEEF and `wr_en` to slot 0 (`INPUT_CH`=0) value 5 → exactly one send for slot 0, value 5.
- Write slot 1 during its SEND cycle → slot 1 sent twice, the second send carrying the new value. Assert reset during GAP → `display_valid` 0 immediately, full repaint follows.
- `LCD_DISP_REFRESH_EN`, `REFRESH_CYCLES`=100, no writes → all slots resent every 100 cycles. Without the macro → no pulses after the initial paint.
